queen_move_executor: RTL

Sequential move executor for the queen: accepts a requested queen move (source, destination), reads the board one square per cycle to verify geometry and path clearance, and writes the board back on a legal move. It is the writer side of the board-state interface that the combinational move-range generators read. It sits between the move-request source (UI/controller) and the board register file.

---
 rtl/queen_move_executor_if.sv | 29 ++
 rtl/queen_move_executor.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/queen_move_executor_if.sv
// Request / board-port bundle between the move source, the queen executor
// and the board register file.
interface queen_move_executor_if;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] src_row, src_col;
  logic [2:0] dst_row, dst_col;
  logic [2:0] rd_row, rd_col;
  logic [4:0] rd_data;
  logic       wr_en;
  logic [2:0] wr_row, wr_col;
  logic [4:0] wr_data;
  logic       done;
  logic       legal;
  logic       capture;
  logic [2:0] captured_type;

  modport slave (
    input  req_valid, src_row, src_col, dst_row, dst_col, rd_data,
    output req_ready, rd_row, rd_col, wr_en, wr_row, wr_col, wr_data,
           done, legal, capture, captured_type
  );

  modport master (
    output req_valid, src_row, src_col, dst_row, dst_col, rd_data,
    input  req_ready, rd_row, rd_col, wr_en, wr_row, wr_col, wr_data,
           done, legal, capture, captured_type
  );
endinterface

// File: rtl/queen_move_executor.sv
// Queen move executor: checks source piece and geometry, walks the path one
// square per cycle, then writes destination and clears source on a legal move.
module queen_move_executor #(
  parameter logic [2:0] QUEEN_TYPE = 3'b101
) (
  input logic                  clk,
  input logic                  rst_n,
  queen_move_executor_if.slave bus
);

  typedef enum logic [2:0] {IDLE, SRC, WALK, W_DST, W_SRC, DONE} state_t;

  state_t            state_q, state_d;
  logic [2:0]        src_row_q, src_row_d, src_col_q, src_col_d;
  logic [2:0]        dst_row_q, dst_row_d, dst_col_q, dst_col_d;
  logic signed [3:0] dr_q, dr_d, dc_q, dc_d;
  logic              color_q, color_d;
  logic              cap_q, cap_d;
  logic [2:0]        cap_type_q, cap_type_d;
  logic              req_ready_q, req_ready_d;
  logic [2:0]        rd_row_q, rd_row_d, rd_col_q, rd_col_d;
  logic              wr_en_q, wr_en_d;
  logic [2:0]        wr_row_q, wr_row_d, wr_col_q, wr_col_d;
  logic [4:0]        wr_data_q, wr_data_d;
  logic              done_q, done_d;
  logic              legal_q, legal_d;
  logic              capture_q, capture_d;
  logic [2:0]        captured_type_q, captured_type_d;

  logic signed [3:0] step_r, step_c, nxt_r, nxt_c;
  logic [3:0]        abs_r, abs_c;
  logic              bad_geom, at_dst, occ, reject;

  always_comb begin
    step_r   = (dr_q > 4'sd0) ? 4'sd1 : (dr_q < 4'sd0) ? -4'sd1 : 4'sd0;
    step_c   = (dc_q > 4'sd0) ? 4'sd1 : (dc_q < 4'sd0) ? -4'sd1 : 4'sd0;
    abs_r    = dr_q[3] ? 4'(-dr_q) : 4'(dr_q);
    abs_c    = dc_q[3] ? 4'(-dc_q) : 4'(dc_q);
    // Straight lines have exactly one zero delta; anything else must be diagonal.
    bad_geom = ((dr_q == 4'sd0) && (dc_q == 4'sd0)) ||
               (!((dr_q == 4'sd0) ^ (dc_q == 4'sd0)) && (abs_r != abs_c));
    // The read address doubles as the walk cursor.
    nxt_r    = $signed({1'b0, rd_row_q}) + step_r;
    nxt_c    = $signed({1'b0, rd_col_q}) + step_c;
    at_dst   = (rd_row_q == dst_row_q) && (rd_col_q == dst_col_q);
    occ      = bus.rd_data[0];
  end

  always_comb begin
    state_d         = state_q;
    src_row_d       = src_row_q;
    src_col_d       = src_col_q;
    dst_row_d       = dst_row_q;
    dst_col_d       = dst_col_q;
    dr_d            = dr_q;
    dc_d            = dc_q;
    color_d         = color_q;
    cap_d           = cap_q;
    cap_type_d      = cap_type_q;
    legal_d         = legal_q;
    capture_d       = capture_q;
    captured_type_d = captured_type_q;
    req_ready_d     = 1'b0;
    rd_row_d        = 3'd0;
    rd_col_d        = 3'd0;
    wr_en_d         = 1'b0;
    wr_row_d        = 3'd0;
    wr_col_d        = 3'd0;
    wr_data_d       = 5'd0;
    done_d          = 1'b0;
    reject          = 1'b0;

    case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        if (bus.req_valid) begin
          src_row_d   = bus.src_row;
          src_col_d   = bus.src_col;
          dst_row_d   = bus.dst_row;
          dst_col_d   = bus.dst_col;
          dr_d        = $signed({1'b0, bus.dst_row}) - $signed({1'b0, bus.src_row});
          dc_d        = $signed({1'b0, bus.dst_col}) - $signed({1'b0, bus.src_col});
          rd_row_d    = bus.src_row;
          rd_col_d    = bus.src_col;
          req_ready_d = 1'b0;
          state_d     = SRC;
        end
      end
      SRC: begin
        if (!occ || bus.rd_data[4:2] != QUEEN_TYPE || bad_geom) begin
          reject = 1'b1;
        end else begin
          color_d  = bus.rd_data[1];
          rd_row_d = nxt_r[2:0];
          rd_col_d = nxt_c[2:0];
          state_d  = WALK;
        end
      end
      WALK: begin
        if (!at_dst) begin
          if (occ) begin
            reject = 1'b1;
          end else begin
            rd_row_d = nxt_r[2:0];
            rd_col_d = nxt_c[2:0];
          end
        end else if (occ && bus.rd_data[1] == color_q) begin
          reject = 1'b1;
        end else begin
          cap_d      = occ;
          cap_type_d = occ ? bus.rd_data[4:2] : 3'd0;
          wr_en_d    = 1'b1;
          wr_row_d   = dst_row_q;
          wr_col_d   = dst_col_q;
          wr_data_d  = {QUEEN_TYPE, color_q, 1'b1};
          state_d    = W_DST;
        end
      end
      W_DST: begin
        wr_en_d  = 1'b1;
        wr_row_d = src_row_q;
        wr_col_d = src_col_q;
        state_d  = W_SRC;
      end
      W_SRC: begin
        done_d          = 1'b1;
        legal_d         = 1'b1;
        capture_d       = cap_q;
        captured_type_d = cap_type_q;
        state_d         = DONE;
      end
      DONE: begin
        req_ready_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (reject) begin
      done_d          = 1'b1;
      legal_d         = 1'b0;
      capture_d       = 1'b0;
      captured_type_d = 3'd0;
      rd_row_d        = 3'd0;
      rd_col_d        = 3'd0;
      state_d         = DONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      src_row_q       <= 3'd0;
      src_col_q       <= 3'd0;
      dst_row_q       <= 3'd0;
      dst_col_q       <= 3'd0;
      dr_q            <= 4'sd0;
      dc_q            <= 4'sd0;
      color_q         <= 1'b0;
      cap_q           <= 1'b0;
      cap_type_q      <= 3'd0;
      req_ready_q     <= 1'b1;
      rd_row_q        <= 3'd0;
      rd_col_q        <= 3'd0;
      wr_en_q         <= 1'b0;
      wr_row_q        <= 3'd0;
      wr_col_q        <= 3'd0;
      wr_data_q       <= 5'd0;
      done_q          <= 1'b0;
      legal_q         <= 1'b0;
      capture_q       <= 1'b0;
      captured_type_q <= 3'd0;
    end else begin
      state_q         <= state_d;
      src_row_q       <= src_row_d;
      src_col_q       <= src_col_d;
      dst_row_q       <= dst_row_d;
      dst_col_q       <= dst_col_d;
      dr_q            <= dr_d;
      dc_q            <= dc_d;
      color_q         <= color_d;
      cap_q           <= cap_d;
      cap_type_q      <= cap_type_d;
      req_ready_q     <= req_ready_d;
      rd_row_q        <= rd_row_d;
      rd_col_q        <= rd_col_d;
      wr_en_q         <= wr_en_d;
      wr_row_q        <= wr_row_d;
      wr_col_q        <= wr_col_d;
      wr_data_q       <= wr_data_d;
      done_q          <= done_d;
      legal_q         <= legal_d;
      capture_q       <= capture_d;
      captured_type_q <= captured_type_d;
    end
  end

  assign bus.req_ready     = req_ready_q;
  assign bus.rd_row        = rd_row_q;
  assign bus.rd_col        = rd_col_q;
  assign bus.wr_en         = wr_en_q;
  assign bus.wr_row        = wr_row_q;
  assign bus.wr_col        = wr_col_q;
  assign bus.wr_data       = wr_data_q;
  assign bus.done          = done_q;
  assign bus.legal         = legal_q;
  assign bus.capture       = capture_q;
  assign bus.captured_type = captured_type_q;

endmodule
